pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline.
- Decides every cycle whether the fetch stage proceeds, flushes, or holds:
  - drives the PC-hold and redirect selects;
  - drives the 2-bit IF/ID update code (00 go on, 01 flush to zero, 10 keep);
  - drives the ID/EX bubble insert.
- Sources handled: load-use hazards, taken branches resolved in EX, jumps decoded in ID, and HI/LO reads while the multi-cycle mult/div unit is busy.
- Keeps saturating stall and flush performance counters.

Parameters:
- MD_CYCLES, 4, number of cycles the mult/div unit stays busy after issue; legal range 1..15.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_uses_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo).
- id_isjump  in  1  ID holds j/jal/jr/jalr.
- ex_memread  in  1  EX instruction is a load.
- ex_rt  in  5  destination register of the EX load.
- ex_branch_taken  in  1  branch in EX resolved taken (zero && isbranch).
- ex_md_start  in  1  mult/div instruction is in EX this cycle (issue pulse).
- perf_clr  in  1  synchronous clear of both performance counters.
- pc_keep  out  1  hold PC.
- dobranch  out  1  select the branch target as next PC.
- dojump  out  1  select the jump target as next PC.
- if_next_cond  out  2  IF/ID update code: 00 go on, 01 flush, 10 keep.
- id_ex_flush  out  1  load a bubble (all-zero control) into ID/EX.
- md_busy  out  1  mult/div unit busy.
- stall_cnt  out  CNT_W  cycles spent stalled.
- flush_cnt  out  CNT_W  cycles in which IF/ID was flushed.

Behaviour:
- Reset (reset=0, asynchronous):
  - md counter = 0; stall_cnt = 0; flush_cnt = 0.
  - Outputs forced for the whole reset period: pc_keep=0, dobranch=0, dojump=0, if_next_cond=00, id_ex_flush=0, md_busy=0.
  - Reset mid-operation aborts any busy window; the next cycle after release is a plain go-on.
- Hazard terms (combinational, evaluated in the current cycle):
  - lu = ex_memread && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt)).
  - hl = md_busy && id_uses_hilo.
- Control outputs are combinational from registered state plus inputs. Strict priority, first match wins:
  1. ex_branch_taken:
     - dobranch=1, pc_keep=0, if_next_cond=01, id_ex_flush=1.
     - The ID instruction is squashed, so lu, hl and id_isjump are all ignored.
  2. lu or hl (stall):
     - pc_keep=1, if_next_cond=10, id_ex_flush=1, dobranch=0, dojump=0.
  3. id_isjump:
     - dojump=1, pc_keep=0, if_next_cond=01, id_ex_flush=0; the jump itself proceeds to EX.
  4. Otherwise (go on): all selects 0, if_next_cond=00, id_ex_flush=0.
- The code if_next_cond=11 is never driven.
- Mult/div busy counter md_cnt (4 bits):
  - ex_md_start=1 at edge → md_cnt <= MD_CYCLES; otherwise if md_cnt!=0 → md_cnt <= md_cnt-1.
  - md_busy = (md_cnt!=0). With ex_md_start in cycle t, md_busy is high in cycles t+1 .. t+MD_CYCLES.
  - ex_md_start while already busy restarts the count at MD_CYCLES.
  - ex_md_start coincident with ex_branch_taken is still honoured: the older instruction is in EX, not flushed.
- A hl stall lasting across the cycle where md_cnt reaches 0 releases in the first cycle with md_busy=0.
- Performance counters:
  - stall_cnt +1 on each edge where rule 2 is selected.
  - flush_cnt +1 on each edge where if_next_cond==01.
  - Both saturate at all-ones (no wrap).
  - perf_clr has priority over increment: the counter becomes 0 that edge.
- Latency: zero-cycle combinational decision. Registered state is limited to md_cnt and the counters.

Test Plan:
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, id_uses_rs=1 for one cycle → pc_keep=1, if_next_cond=10, id_ex_flush=1; stall_cnt goes 0→1; next cycle with ex_memread=0 → if_next_cond=00.
- Load to $0: ex_memread=1, ex_rt=0, id_rs=0, id_uses_rs=1 → no stall, if_next_cond=00, stall_cnt stays 0.
- Branch over stall: ex_branch_taken=1 together with the load-use condition and id_isjump=1 → dobranch=1, dojump=0, pc_keep=0, if_next_cond=01, id_ex_flush=1; flush_cnt +1, stall_cnt unchanged.
- Jump: id_isjump=1, no hazards → dojump=1, if_next_cond=01, id_ex_flush=0.
- HI/LO stall (MD_CYCLES=4): ex_md_start pulse at cycle 0, id_uses_hilo=1 held → md_busy high cycles 1–4, stall (if_next_cond=10) cycles 1–4, go on at cycle 5, stall_cnt=4; re-pulse at cycle 2 extends md_busy through cycle 6.
- Saturation/reset: force 70000 stall cycles (CNT_W=16) → stall_cnt holds 0xFFFF; perf_clr → 0; reset driven low mid-busy → md_busy=0 and all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Decides each cycle whether fetch proceeds, flushes or holds, using:
//   - load-use hazards,
//   - taken branches resolved in EX,
//   - jumps decoded in ID,
//   - HI/LO reads while the multi-cycle mult/div unit is busy.
// Keeps saturating stall and flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_uses_hilo,
    input  logic             id_isjump,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    input  logic             perf_clr,
    output logic             pc_keep,
    output logic             dobranch,
    output logic             dojump,
    output logic [1:0]       if_next_cond,
    output logic             id_ex_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // IF/ID update codes
    localparam logic [1:0] IF_GO    = 2'b00;
    localparam logic [1:0] IF_FLUSH = 2'b01;
    localparam logic [1:0] IF_KEEP  = 2'b10;

    localparam logic [3:0]       MD_LOAD = 4'(MD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       md_cnt_q,    md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic md_busy_s;
    logic lu_s;
    logic hl_s;
    logic stall_sel_s;
    logic flush_sel_s;

    // Hazard detection: load-use against a non-zero destination, and HI/LO reads while mult/div is busy
    always_comb begin
        md_busy_s = (md_cnt_q != 4'd0);
        lu_s = ex_memread && (ex_rt != 5'd0) &&
               ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
        hl_s = md_busy_s && id_uses_hilo;
    end

    // Prioritised fetch decision: branch squashes ID, then stalls, then jumps, else go on; all quiet in reset
    always_comb begin
        pc_keep      = 1'b0;
        dobranch     = 1'b0;
        dojump       = 1'b0;
        if_next_cond = IF_GO;
        id_ex_flush  = 1'b0;
        md_busy      = 1'b0;
        stall_sel_s  = 1'b0;
        if (!reset) begin
            md_busy = 1'b0;
        end else begin
            md_busy = md_busy_s;
            if (ex_branch_taken) begin
                dobranch     = 1'b1;
                if_next_cond = IF_FLUSH;
                id_ex_flush  = 1'b1;
            end else if (lu_s || hl_s) begin
                pc_keep      = 1'b1;
                if_next_cond = IF_KEEP;
                id_ex_flush  = 1'b1;
                stall_sel_s  = 1'b1;
            end else if (id_isjump) begin
                dojump       = 1'b1;
                if_next_cond = IF_FLUSH;
            end else begin
                if_next_cond = IF_GO;
            end
        end
        flush_sel_s = (if_next_cond == IF_FLUSH);
    end

    // Mult/div busy window: an issue (re)loads the count, otherwise count down to zero
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (ex_md_start) begin
            md_cnt_d = MD_LOAD;
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end else begin
            md_cnt_d = md_cnt_q;
        end
    end

    // Saturating performance counters; a clear wins over an increment in the same cycle
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (stall_sel_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (perf_clr) begin
            flush_cnt_d = {CNT_W{1'b0}};
        end else if (flush_sel_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MD_CYCLES=4, CNT_W=16).
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, id_uses_hilo, id_isjump;
    logic        ex_memread, ex_branch_taken, ex_md_start, perf_clr;
    logic        pc_keep, dobranch, dojump, id_ex_flush, md_busy;
    logic [1:0]  if_next_cond;
    logic [15:0] stall_cnt, flush_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipeline_hazard_ctrl #(.MD_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_uses_hilo(id_uses_hilo), .id_isjump(id_isjump),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .ex_md_start(ex_md_start), .perf_clr(perf_clr),
        .pc_keep(pc_keep), .dobranch(dobranch), .dojump(dojump),
        .if_next_cond(if_next_cond), .id_ex_flush(id_ex_flush), .md_busy(md_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the five fetch-control outputs as one packed vector {pc_keep,dobranch,dojump,if_next_cond,id_ex_flush}
    task automatic check_ctl(input string tag, input logic [5:0] exp);
        check(tag, {26'd0, pc_keep, dobranch, dojump, if_next_cond, id_ex_flush}, {26'd0, exp});
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_uses_hilo = 1'b0; id_isjump = 1'b0;
        ex_memread = 1'b0; ex_branch_taken = 1'b0; ex_md_start = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // control vectors {pc_keep,dobranch,dojump,if_next_cond[1:0],id_ex_flush}
    localparam logic [5:0] C_GO     = 6'b000_00_0;
    localparam logic [5:0] C_STALL  = 6'b100_10_1;
    localparam logic [5:0] C_BRANCH = 6'b010_01_1;
    localparam logic [5:0] C_JUMP   = 6'b001_01_0;

    initial begin
        reset = 1'b0;
        clear_inputs();
        #3;
        check_ctl("reset_ctl", C_GO);
        check("reset_busy", {31'd0, md_busy}, 32'd0);
        check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("reset_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        ex_branch_taken = 1'b1; id_isjump = 1'b1;
        #1;
        check_ctl("reset_forces_ctl", C_GO);
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        tick();

        // load-use on rs
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        #1;
        check_ctl("lu_rs_ctl", C_STALL);
        check("lu_rs_cnt_before", {16'd0, stall_cnt}, 32'd0);
        tick(); exp_stall++;
        ex_memread = 1'b0;
        #1;
        check("lu_rs_cnt_after", {16'd0, stall_cnt}, 32'(exp_stall));
        check_ctl("lu_release", C_GO);

        // load-use on rt only; rs mismatched
        clear_inputs();
        ex_memread = 1'b1; ex_rt = 5'd17; id_rt = 5'd17; id_uses_rt = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
        #1;
        check_ctl("lu_rt_ctl", C_STALL);
        tick(); exp_stall++;
        // rt matches but instruction does not read rt
        id_uses_rt = 1'b0;
        #1;
        check_ctl("lu_rt_unused", C_GO);

        // load to $0 is never a hazard
        clear_inputs();
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #1;
        check_ctl("lu_zero_ctl", C_GO);
        tick();
        check("lu_zero_cnt", {16'd0, stall_cnt}, 32'(exp_stall));

        // branch overrides load-use and jump
        clear_inputs();
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        id_isjump = 1'b1; ex_branch_taken = 1'b1;
        #1;
        check_ctl("branch_ctl", C_BRANCH);
        tick(); exp_flush++;
        check("branch_flush_cnt", {16'd0, flush_cnt}, 32'(exp_flush));
        check("branch_stall_cnt", {16'd0, stall_cnt}, 32'(exp_stall));

        // stall overrides jump
        ex_branch_taken = 1'b0;
        #1;
        check_ctl("stall_over_jump", C_STALL);
        tick(); exp_stall++;

        // plain jump
        clear_inputs();
        id_isjump = 1'b1;
        #1;
        check_ctl("jump_ctl", C_JUMP);
        tick(); exp_flush++;
        check("jump_flush_cnt", {16'd0, flush_cnt}, 32'(exp_flush));
        check("jump_stall_cnt", {16'd0, stall_cnt}, 32'(exp_stall));

        // HI/LO stall across a 4-cycle mult/div window
        clear_inputs();
        ex_md_start = 1'b1; id_uses_hilo = 1'b1;
        #1;
        check_ctl("hl_cycle0", C_GO);
        tick();
        ex_md_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check($sformatf("hl_busy_c%0d", i), {31'd0, md_busy}, 32'd1);
            check_ctl($sformatf("hl_stall_c%0d", i), C_STALL);
            tick(); exp_stall++;
        end
        #1;
        check("hl_busy_c5", {31'd0, md_busy}, 32'd0);
        check_ctl("hl_go_c5", C_GO);
        check("hl_stall_cnt", {16'd0, stall_cnt}, 32'(exp_stall));

        // re-pulse at cycle 2 extends busy through cycle 6
        clear_inputs();
        ex_md_start = 1'b1;
        tick();                         // cycle 1
        ex_md_start = 1'b0;
        tick();                         // cycle 2
        ex_md_start = 1'b1;
        tick();                         // cycle 3
        ex_md_start = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            #1;
            check($sformatf("repulse_busy_c%0d", c), {31'd0, md_busy}, 32'd1);
            tick();
        end
        #1;
        check("repulse_busy_c7", {31'd0, md_busy}, 32'd0);

        // mult/div issue coincident with a taken branch is honoured
        clear_inputs();
        ex_md_start = 1'b1; ex_branch_taken = 1'b1;
        tick(); exp_flush++;
        clear_inputs();
        #1;
        check("md_with_branch_busy", {31'd0, md_busy}, 32'd1);
        check("md_with_branch_flush", {16'd0, flush_cnt}, 32'(exp_flush));
        repeat (4) tick();

        // stall counter saturates
        clear_inputs();
        ex_memread = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        check("stall_saturate", {16'd0, stall_cnt}, 32'h0000_FFFF);
        perf_clr = 1'b1;
        tick();
        check("clr_stall", {16'd0, stall_cnt}, 32'd0);
        check("clr_flush", {16'd0, flush_cnt}, 32'd0);
        perf_clr = 1'b0;
        tick();
        check("count_after_clr", {16'd0, stall_cnt}, 32'd1);

        // asynchronous reset mid-busy
        clear_inputs();
        ex_md_start = 1'b1;
        tick();
        ex_md_start = 1'b0; id_uses_hilo = 1'b1; id_isjump = 1'b1;
        #1;
        check("pre_reset_busy", {31'd0, md_busy}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check_ctl("async_reset_ctl", C_GO);
        check("async_reset_busy", {31'd0, md_busy}, 32'd0);
        check("async_reset_stall", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        id_isjump = 1'b0;
        #1;
        check_ctl("post_reset_go", C_GO);
        check("post_reset_busy", {31'd0, md_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
